qspi_bus_arbiter: RTL and testbench
===================================

Name: qspi_bus_arbiter

Overview:
- Shares one QSPI pin set (sclk, sio[3:0], sio_oe) between two masters: the PSRAM controller (CE0) and the NOR flash controller (CE1).
- Sits between the two memory controllers inside soc and the top-level pad/PMOD mux.
- Provides round-robin arbitration, a guaranteed CE-deselect gap between owners, and a PSRAM CE-low watchdog that requests a burst break.

Parameters:
- CS_GAP, 2: cycles both CEs are held high between any release and the next grant (1..15).
- MAX_LOW, 400: max cycles an owner may hold CE low before its brk is raised; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ram_req  in  1  PSRAM controller requests the bus; held high for the whole transaction
- ram_gnt  out  1  bus granted to the PSRAM controller
- ram_brk  out  1  PSRAM owner must end its burst (watchdog)
- ram_sclk  in  1  PSRAM controller clock to pins
- ram_sio_o  in  4  PSRAM controller data out
- ram_sio_oe  in  4  PSRAM controller output enables
- nor_req, nor_gnt, nor_brk, nor_sclk, nor_sio_o[4], nor_sio_oe[4]: same roles for the NOR controller
- sio_i  in  4  pin input data, broadcast to both controllers unmodified
- ce0  out  1  PSRAM chip enable, active low
- ce1  out  1  NOR chip enable, active low
- sclk  out  1  shared pin clock
- sio_o  out  4  shared pin data out
- sio_oe  out  4  shared pin output enables
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state=IDLE, last=NOR (so PSRAM wins the first tie)
  - ram_gnt=nor_gnt=0, ram_brk=nor_brk=0
  - ce0=ce1=1, sclk=0, sio_o=0, sio_oe=0, busy=0
  - gap and watchdog counters = 0
- States: IDLE, OWN_RAM, OWN_NOR, GAP.
- IDLE:
  - Only ram_req -> OWN_RAM. Only nor_req -> OWN_NOR.
  - Both requests -> grant the requester that is not `last`; update `last` on every grant.
- Grant timing (gnt and ce are registered):
  - Request sampled high in IDLE at edge N -> gnt=1 and the owner's ce=0 from edge N+1.
  - Minimum request-to-grant latency is 1 cycle.
- OWN_x:
  - Pins follow owner x combinationally: sclk=x_sclk, sio_o=x_sio_o, sio_oe=x_sio_oe.
  - The non-owner's gnt=0 and its ce=1.
  - x_req sampled low -> GAP next edge; gnt=0 and ce=1 from that edge.
- GAP:
  - Both CEs high; sclk=0, sio_oe=0, sio_o=0.
  - Counter runs 0..CS_GAP-1, then -> IDLE, which evaluates requests on the following edge.
  - Release to next grant is CS_GAP+1 cycles.
  - Pending requests wait; they are never lost.
- IDLE pin values: same as GAP (sclk=0, sio_oe=0).
- Watchdog:
  - Counter clears on entry to OWN_x and increments each cycle in OWN_x, saturating at MAX_LOW.
  - When the count reaches MAX_LOW-1, x_brk goes high next edge and stays high until the state leaves OWN_x.
  - No forced preemption: the arbiter waits for x_req to drop.
- Simultaneous events:
  - Owner drops req while the other requester is asserting -> GAP first, always.
  - A request asserted in the same cycle the owner releases is served after GAP.
- Request withdrawal: a non-granted requester may drop req at any time with no effect.
- Protocol assertion: the owner must not drop req while its own sclk=1. The bench checks this; the RTL is not required to tolerate it.
- Reset mid-transaction: CEs go high asynchronously and the bus is tri-stated immediately.
- Invariant: ce0 & ce1 never both 0, and never both gnt=1.

Decomposition:
- Shared package qspi_pkg holds:
  - state encoding: IDLE=2'd0, OWN_RAM=2'd1, OWN_NOR=2'd2, GAP=2'd3
  - requester index constants: REQ_RAM=0, REQ_NOR=1
  - QSPI_W=4
- One sub-module: qspi_ce_watchdog, a saturating counter with brk output, instantiated once and reused by whichever requester owns the bus.

Test Plan:
- Reset: rst pulse mid-OWN_RAM -> ce0=1 and sio_oe=0 within the same cycle, state=IDLE, ram_gnt=0.
- Single requester: ram_req rises at cycle 0 -> ram_gnt=1, ce0=0 at cycle 1.
  - Drop at cycle 10 -> ce0=1 at cycle 11, busy=0 at cycle 11+CS_GAP.
- Tie: ram_req and nor_req both high from reset release -> RAM granted first.
  - After RAM releases, NOR is granted exactly CS_GAP+1 cycles later.
  - Next tie goes to RAM.
- Back-to-back with CS_GAP=3: ce0 rises at cycle T -> ce1 falls no earlier than T+4; both CEs never low in the same cycle.
- Watchdog with MAX_LOW=8: hold nor_req for 20 cycles -> nor_brk=1 from grant+8 until release; ram_brk stays 0.
  - With MAX_LOW=0, brk never asserts.
- Pin mux: while OWN_NOR, nor_sio_o=4'hA and nor_sio_oe=4'hF -> sio_o=4'hA, sio_oe=4'hF, ram_* pin inputs ignored.
  - sio_i=4'h5 is seen by both controllers.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI bus arbiter: FSM encoding,
// requester indices and the QSPI data width.
package qspi_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_RAM = 2'd1,
      OWN_NOR = 2'd2,
      GAP     = 2'd3
   } state_t;

   localparam bit REQ_RAM = 1'b0;
   localparam bit REQ_NOR = 1'b1;

   localparam int QSPI_W = 4;

endpackage

// File: rtl/qspi_ce_watchdog.sv
// CE-low watchdog: counts cycles of bus ownership (saturating at MAX_LOW) and
// raises brk once the owner has held CE low for MAX_LOW cycles.
module qspi_ce_watchdog #(
   parameter int MAX_LOW = 400
) (
   input  logic clk,
   input  logic rst,
   input  logic own,
   input  logic own_next,
   output logic brk
);

   localparam int CW = (MAX_LOW < 2) ? 1 : $clog2(MAX_LOW + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_LOW);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOW - 1);

   logic [CW-1:0] cnt_q;
   logic          brk_q;

   // Clearing on !own_next drops brk on the very edge the owner leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         brk_q <= 1'b0;
      end else if (!own_next) begin
         cnt_q <= '0;
         brk_q <= 1'b0;
      end else if (own && (MAX_LOW != 0)) begin
         if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) brk_q <= 1'b1;
      end
   end

   assign brk = brk_q;

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Round-robin owner of one QSPI pin set shared by the PSRAM (CE0) and NOR
// (CE1) controllers, with a guaranteed CE-deselect gap and CE-low watchdog.
module qspi_bus_arbiter
   import qspi_pkg::*;
#(
   parameter int CS_GAP  = 2,
   parameter int MAX_LOW = 400
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_req,
   output logic              ram_gnt,
   output logic              ram_brk,
   input  logic              ram_sclk,
   input  logic [QSPI_W-1:0] ram_sio_o,
   input  logic [QSPI_W-1:0] ram_sio_oe,
   output logic [QSPI_W-1:0] ram_sio_i,
   input  logic              nor_req,
   output logic              nor_gnt,
   output logic              nor_brk,
   input  logic              nor_sclk,
   input  logic [QSPI_W-1:0] nor_sio_o,
   input  logic [QSPI_W-1:0] nor_sio_oe,
   output logic [QSPI_W-1:0] nor_sio_i,
   input  logic [QSPI_W-1:0] sio_i,
   output logic              ce0,
   output logic              ce1,
   output logic              sclk,
   output logic [QSPI_W-1:0] sio_o,
   output logic [QSPI_W-1:0] sio_oe,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

   // Handshake: x_req is held high for the whole transaction; x_gnt rises one
   // edge after req is sampled in IDLE and falls on the edge req is seen low.
   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic [3:0] gap_q, gap_d;
   logic       own_q, own_d, wd_brk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= REQ_NOR;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            gap_d = '0;
            if (ram_req && (!nor_req || (last_q == REQ_NOR))) begin
               state_d = OWN_RAM;
               last_d  = REQ_RAM;
            end else if (nor_req) begin
               state_d = OWN_NOR;
               last_d  = REQ_NOR;
            end
         end
         OWN_RAM: begin
            gap_d = '0;
            if (!ram_req) state_d = GAP;
         end
         OWN_NOR: begin
            gap_d = '0;
            if (!nor_req) state_d = GAP;
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pins idle low whenever nobody owns the bus, including during reset.
   always_comb begin
      sclk   = 1'b0;
      sio_o  = '0;
      sio_oe = '0;
      case (state_q)
         OWN_RAM: begin
            sclk   = ram_sclk;
            sio_o  = ram_sio_o;
            sio_oe = ram_sio_oe;
         end
         OWN_NOR: begin
            sclk   = nor_sclk;
            sio_o  = nor_sio_o;
            sio_oe = nor_sio_oe;
         end
         default: ;
      endcase
   end

   assign own_q = (state_q == OWN_RAM) || (state_q == OWN_NOR);
   assign own_d = (state_d == OWN_RAM) || (state_d == OWN_NOR);

   qspi_ce_watchdog #(.MAX_LOW(MAX_LOW)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .own      (own_q),
      .own_next (own_d),
      .brk      (wd_brk)
   );

   assign ram_gnt   = (state_q == OWN_RAM);
   assign nor_gnt   = (state_q == OWN_NOR);
   assign ram_brk   = wd_brk & ram_gnt;
   assign nor_brk   = wd_brk & nor_gnt;
   assign ce0       = ~ram_gnt;
   assign ce1       = ~nor_gnt;
   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;
   assign ram_sio_i = sio_i;
   assign nor_sio_i = sio_i;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed bench for qspi_bus_arbiter: instance a (CS_GAP=2, MAX_LOW=8) and
// instance b (CS_GAP=3, MAX_LOW=0) share stimulus; expectations are hand-derived.
module tb_qspi_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       ram_req, ram_sclk, nor_req, nor_sclk;
   logic [3:0] ram_sio_o, ram_sio_oe, nor_sio_o, nor_sio_oe, sio_i;

   logic       a_ram_gnt, a_ram_brk, a_nor_gnt, a_nor_brk, a_ce0, a_ce1, a_sclk, a_busy;
   logic [3:0] a_ram_sio_i, a_nor_sio_i, a_sio_o, a_sio_oe;
   logic [1:0] a_state;
   logic       b_ram_gnt, b_ram_brk, b_nor_gnt, b_nor_brk, b_ce0, b_ce1, b_sclk, b_busy;
   logic [3:0] b_ram_sio_i, b_nor_sio_i, b_sio_o, b_sio_oe;
   logic [1:0] b_state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   qspi_bus_arbiter #(.CS_GAP(2), .MAX_LOW(8)) dut_a (
      .clk(clk), .rst(rst),
      .ram_req(ram_req), .ram_gnt(a_ram_gnt), .ram_brk(a_ram_brk), .ram_sclk(ram_sclk),
      .ram_sio_o(ram_sio_o), .ram_sio_oe(ram_sio_oe), .ram_sio_i(a_ram_sio_i),
      .nor_req(nor_req), .nor_gnt(a_nor_gnt), .nor_brk(a_nor_brk), .nor_sclk(nor_sclk),
      .nor_sio_o(nor_sio_o), .nor_sio_oe(nor_sio_oe), .nor_sio_i(a_nor_sio_i),
      .sio_i(sio_i), .ce0(a_ce0), .ce1(a_ce1), .sclk(a_sclk), .sio_o(a_sio_o),
      .sio_oe(a_sio_oe), .busy(a_busy), .state_dbg(a_state)
   );

   qspi_bus_arbiter #(.CS_GAP(3), .MAX_LOW(0)) dut_b (
      .clk(clk), .rst(rst),
      .ram_req(ram_req), .ram_gnt(b_ram_gnt), .ram_brk(b_ram_brk), .ram_sclk(ram_sclk),
      .ram_sio_o(ram_sio_o), .ram_sio_oe(ram_sio_oe), .ram_sio_i(b_ram_sio_i),
      .nor_req(nor_req), .nor_gnt(b_nor_gnt), .nor_brk(b_nor_brk), .nor_sclk(nor_sclk),
      .nor_sio_o(nor_sio_o), .nor_sio_oe(nor_sio_oe), .nor_sio_i(b_nor_sio_i),
      .sio_i(sio_i), .ce0(b_ce0), .ce1(b_ce1), .sclk(b_sclk), .sio_o(b_sio_o),
      .sio_oe(b_sio_oe), .busy(b_busy), .state_dbg(b_state)
   );

   // Invariant: never two chip enables low, never two grants.
   always @(negedge clk) begin
      checks = checks + 1;
      if (!a_ce0 && !a_ce1) begin failures = failures + 1; $display("FAIL a_ce_excl: ce0=%b ce1=%b expected not both 0", a_ce0, a_ce1); end
      if (a_ram_gnt && a_nor_gnt) begin failures = failures + 1; $display("FAIL a_gnt_excl: both gnt=1 expected at most one"); end
      if (!b_ce0 && !b_ce1) begin failures = failures + 1; $display("FAIL b_ce_excl: ce0=%b ce1=%b expected not both 0", b_ce0, b_ce1); end
      if (b_ram_gnt && b_nor_gnt) begin failures = failures + 1; $display("FAIL b_gnt_excl: both gnt=1 expected at most one"); end
   end

   // Protocol: the owner must not drop req while its own sclk is high.
   always @(posedge clk) begin
      if (!rst && a_ram_gnt && !ram_req) begin
         checks = checks + 1;
         if (ram_sclk !== 1'b0) begin failures = failures + 1; $display("FAIL ram_release_sclk: sclk=%b expected 0", ram_sclk); end
      end
      if (!rst && a_nor_gnt && !nor_req) begin
         checks = checks + 1;
         if (nor_sclk !== 1'b0) begin failures = failures + 1; $display("FAIL nor_release_sclk: sclk=%b expected 0", nor_sclk); end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs;
      ram_req = 0; ram_sclk = 0; ram_sio_o = 0; ram_sio_oe = 0;
      nor_req = 0; nor_sclk = 0; nor_sio_o = 0; nor_sio_oe = 0;
      sio_i = 0;
   endtask

   task automatic do_reset;
      rst = 1;
      cyc(1);
      rst = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      idle_inputs();
      cyc(2);
      checks = checks + 1;
      if ({a_ce0, a_ce1, a_ram_gnt, a_nor_gnt, a_ram_brk, a_nor_brk, a_busy, a_sclk} !== 8'b1100_0000) begin
         failures = failures + 1; $display("FAIL reset_ctrl: got %b expected 11000000", {a_ce0, a_ce1, a_ram_gnt, a_nor_gnt, a_ram_brk, a_nor_brk, a_busy, a_sclk});
      end
      checks = checks + 1;
      if ({a_sio_o, a_sio_oe, a_state} !== 10'd0) begin
         failures = failures + 1; $display("FAIL reset_pins: sio_o=%h sio_oe=%h state=%0d expected 0 0 0", a_sio_o, a_sio_oe, a_state);
      end
      rst = 0;
      ram_req = 1; ram_sio_oe = 4'hF; ram_sio_o = 4'h3;
      cyc(1);
      checks = checks + 1;
      if ({a_ce0, a_sio_oe, a_sio_o} !== {1'b0, 4'hF, 4'h3}) begin
         failures = failures + 1; $display("FAIL reset_pre_own: ce0=%b sio_oe=%h sio_o=%h expected 0 f 3", a_ce0, a_sio_oe, a_sio_o);
      end
      #2 rst = 1;
      #1;
      checks = checks + 1;
      if ({a_ce0, a_sio_oe, a_state, a_ram_gnt} !== {1'b1, 4'h0, 2'd0, 1'b0}) begin
         failures = failures + 1; $display("FAIL reset_async: ce0=%b sio_oe=%h state=%0d gnt=%b expected 1 0 0 0", a_ce0, a_sio_oe, a_state, a_ram_gnt);
      end
      idle_inputs();
      cyc(1);
      rst = 0;
      cyc(1);
   endtask

   task automatic test_single;
      ram_req = 1;
      cyc(1);
      checks = checks + 1;
      if ({a_ram_gnt, a_ce0, a_busy, a_nor_gnt, a_ce1} !== 5'b10101) begin
         failures = failures + 1; $display("FAIL single_grant: gnt,ce0,busy,nor_gnt,ce1=%b expected 10101", {a_ram_gnt, a_ce0, a_busy, a_nor_gnt, a_ce1});
      end
      cyc(7);
      checks = checks + 1;
      if (a_ram_brk !== 1'b0) begin failures = failures + 1; $display("FAIL single_brk_early: brk=%b expected 0", a_ram_brk); end
      cyc(1);
      checks = checks + 1;
      if (a_ram_brk !== 1'b1) begin failures = failures + 1; $display("FAIL single_brk: brk=%b expected 1", a_ram_brk); end
      cyc(1);
      ram_req = 0;
      cyc(1);
      checks = checks + 1;
      if ({a_ce0, a_ram_gnt, a_busy, a_state, a_ram_brk} !== {1'b1, 1'b0, 1'b1, 2'd3, 1'b0}) begin
         failures = failures + 1; $display("FAIL single_release: ce0,gnt,busy,state,brk=%b expected 101110", {a_ce0, a_ram_gnt, a_busy, a_state, a_ram_brk});
      end
      cyc(1);
      checks = checks + 1;
      if (a_busy !== 1'b1) begin failures = failures + 1; $display("FAIL single_gap_busy: busy=%b expected 1", a_busy); end
      cyc(1);
      checks = checks + 1;
      if ({a_busy, b_busy} !== 2'b01) begin failures = failures + 1; $display("FAIL single_idle: a_busy,b_busy=%b expected 01", {a_busy, b_busy}); end
      cyc(1);
      checks = checks + 1;
      if (b_busy !== 1'b0) begin failures = failures + 1; $display("FAIL single_idle_b: busy=%b expected 0", b_busy); end
   endtask

   task automatic test_tie;
      ram_req = 1; nor_req = 1;
      do_reset();
      cyc(1);
      checks = checks + 1;
      if ({a_ram_gnt, a_nor_gnt, b_ram_gnt, a_ce1} !== 4'b1011) begin
         failures = failures + 1; $display("FAIL tie_first: a_ram,a_nor,b_ram,ce1=%b expected 1011", {a_ram_gnt, a_nor_gnt, b_ram_gnt, a_ce1});
      end
      cyc(3);
      ram_req = 0;
      cyc(1);
      checks = checks + 1;
      if ({a_state, a_nor_gnt} !== {2'd3, 1'b0}) begin failures = failures + 1; $display("FAIL tie_gap: state=%0d nor_gnt=%b expected 3 0", a_state, a_nor_gnt); end
      cyc(2);
      checks = checks + 1;
      if ({a_state, a_nor_gnt} !== {2'd0, 1'b0}) begin failures = failures + 1; $display("FAIL tie_idle: state=%0d nor_gnt=%b expected 0 0", a_state, a_nor_gnt); end
      cyc(1);
      checks = checks + 1;
      if ({a_nor_gnt, a_ce1, b_nor_gnt} !== 3'b100) begin failures = failures + 1; $display("FAIL tie_second: a_gnt,a_ce1,b_gnt=%b expected 100", {a_nor_gnt, a_ce1, b_nor_gnt}); end
      cyc(1);
      checks = checks + 1;
      if (b_nor_gnt !== 1'b1) begin failures = failures + 1; $display("FAIL tie_second_b: gnt=%b expected 1", b_nor_gnt); end
      ram_req = 1;
      cyc(2);
      nor_req = 0;
      cyc(1);
      checks = checks + 1;
      if ({a_state, a_ram_gnt} !== {2'd3, 1'b0}) begin failures = failures + 1; $display("FAIL tie_gap_first: state=%0d ram_gnt=%b expected 3 0", a_state, a_ram_gnt); end
      nor_req = 1;
      cyc(3);
      checks = checks + 1;
      if ({a_ram_gnt, a_nor_gnt} !== 2'b10) begin failures = failures + 1; $display("FAIL tie_rr: ram,nor=%b expected 10", {a_ram_gnt, a_nor_gnt}); end
      ram_req = 0; nor_req = 0;
      cyc(6);
   endtask

   task automatic test_back_to_back;
      int ra, fa, rb, fb;
      logic pa0, pa1, pb0, pb1;
      ram_req = 1; nor_req = 1;
      do_reset();
      cyc(3);
      ram_req = 0;
      ra = -1; fa = -1; rb = -1; fb = -1;
      pa0 = a_ce0; pa1 = a_ce1; pb0 = b_ce0; pb1 = b_ce1;
      for (int k = 1; k <= 20; k++) begin
         cyc(1);
         if (!pa0 && a_ce0 && ra < 0) ra = k;
         if (pa1 && !a_ce1 && fa < 0) fa = k;
         if (!pb0 && b_ce0 && rb < 0) rb = k;
         if (pb1 && !b_ce1 && fb < 0) fb = k;
         pa0 = a_ce0; pa1 = a_ce1; pb0 = b_ce0; pb1 = b_ce1;
      end
      checks = checks + 1;
      if (rb < 0 || fb - rb != 4) begin failures = failures + 1; $display("FAIL b2b_gap3: rise=%0d fall=%0d expected fall-rise=4", rb, fb); end
      checks = checks + 1;
      if (ra < 0 || fa - ra != 3) begin failures = failures + 1; $display("FAIL b2b_gap2: rise=%0d fall=%0d expected fall-rise=3", ra, fa); end
      nor_req = 0;
      cyc(6);
   endtask

   task automatic test_watchdog;
      do_reset();
      nor_req = 1;
      cyc(1);
      for (int k = 0; k < 19; k++) begin
         checks = checks + 1;
         if ({a_nor_brk, a_ram_brk, b_nor_brk, a_nor_gnt} !== {(k >= 8), 1'b0, 1'b0, 1'b1}) begin
            failures = failures + 1; $display("FAIL wd_k%0d: a_nor,a_ram,b_nor,gnt=%b expected %b001", k, {a_nor_brk, a_ram_brk, b_nor_brk, a_nor_gnt}, (k >= 8));
         end
         cyc(1);
      end
      nor_req = 0;
      cyc(1);
      checks = checks + 1;
      if ({a_nor_brk, a_nor_gnt} !== 2'b00) begin failures = failures + 1; $display("FAIL wd_release: brk,gnt=%b expected 00", {a_nor_brk, a_nor_gnt}); end
      cyc(5);
   endtask

   task automatic test_pin_mux;
      do_reset();
      nor_req = 1;
      cyc(1);
      nor_sio_o = 4'hA; nor_sio_oe = 4'hF; nor_sclk = 1;
      ram_sio_o = 4'h5; ram_sio_oe = 4'h3; ram_sclk = 0; sio_i = 4'h5;
      #1;
      checks = checks + 1;
      if ({a_sio_o, a_sio_oe, a_sclk} !== {4'hA, 4'hF, 1'b1}) begin
         failures = failures + 1; $display("FAIL mux_nor: sio_o=%h sio_oe=%h sclk=%b expected a f 1", a_sio_o, a_sio_oe, a_sclk);
      end
      checks = checks + 1;
      if ({a_ram_sio_i, a_nor_sio_i} !== 8'h55) begin failures = failures + 1; $display("FAIL mux_sio_i: ram=%h nor=%h expected 5 5", a_ram_sio_i, a_nor_sio_i); end
      ram_sio_o = 4'hC; ram_sio_oe = 4'h0; ram_sclk = 1; sio_i = 4'h9;
      #1;
      checks = checks + 1;
      if ({a_sio_o, a_sio_oe, a_sclk, a_nor_sio_i} !== {4'hA, 4'hF, 1'b1, 4'h9}) begin
         failures = failures + 1; $display("FAIL mux_ignore_ram: sio_o=%h sio_oe=%h sclk=%b nor_sio_i=%h expected a f 1 9", a_sio_o, a_sio_oe, a_sclk, a_nor_sio_i);
      end
      cyc(1);
      nor_sclk = 0; ram_sclk = 0;
      nor_req = 0;
      cyc(1);
      checks = checks + 1;
      if ({a_sio_o, a_sio_oe, a_sclk} !== 9'd0) begin
         failures = failures + 1; $display("FAIL mux_gap: sio_o=%h sio_oe=%h sclk=%b expected 0 0 0", a_sio_o, a_sio_oe, a_sclk);
      end
      idle_inputs();
      cyc(5);
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_back_to_back();
      test_watchdog();
      test_pin_mux();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures = failures + 1;
      $display("FAIL timeout: simulation did not complete expected before 100000 time units");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
